// File: rtl/imem_arbiter.sv
// Round-robin arbiter that shares one combinational-read instruction ROM between
// the IFU (port 0) and the LSU (port 1). Optional misalignment check: IMEM_ALIGN_CHECK_EN.
module imem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state;
  logic              gnt_id;
  logic              rr_ptr;
  logic              can_accept;
  logic              winner;
  logic              grant;
  logic              misaligned;
  logic [ADDR_W-1:0] win_addr;

  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    can_accept = (state == IDLE) |
                 ((state == RESP) & resp_valid[gnt_id] & resp_ready[gnt_id]);
    winner     = (&req_valid) ? rr_ptr : req_valid[1];
    // Gating with rst_n keeps req_ready low for the whole reset, not just after the first edge.
    grant      = rst_n & (|req_valid) & can_accept;
    win_addr   = winner ? req_addr1 : req_addr0;
    req_ready  = 2'b00;
    if (grant) req_ready[winner] = 1'b1;
    rom_addr   = grant ? win_addr : '0;
`ifdef IMEM_ALIGN_CHECK_EN
    misaligned = |win_addr[1:0];
`else
    misaligned = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_id     <= 1'b0;
      rr_ptr     <= 1'b0;
      resp_valid <= 2'b00;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (grant) begin
      // A retiring response and a new grant share this edge, so there is no bubble.
      state      <= RESP;
      gnt_id     <= winner;
      rr_ptr     <= ~winner;
      resp_valid <= winner ? 2'b10 : 2'b01;
      resp_data  <= misaligned ? '0 : rom_data;
      resp_err   <= misaligned;
    end else if (state == RESP && resp_ready[gnt_id]) begin
      state      <= IDLE;
      resp_valid <= 2'b00;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a driver predicts grants from the arbitration
// rules and queues expected responses; an independent monitor pops and compares.
module tb_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  int          vectors;
  int          miscompares;
  logic [31:0] last_data;
  logic        last_err;

  // Reference view of the arbiter: who is being served and who is owed the next turn.
  logic        m_busy;
  logic        m_port;
  logic        m_owed;

  imem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    case (idx)
      32'd0:   return 32'h0000_0513;
      32'd1:   return 32'h0480_0593;
      32'd2:   return 32'h0010_0073;
      default: return (idx * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  function automatic exp_t expected_resp(input logic port, input logic [31:0] addr);
    exp_t e;
    e.port = port;
`ifdef IMEM_ALIGN_CHECK_EN
    e.err  = (addr[1:0] != 2'b00);
    e.data = e.err ? 32'h0 : rom_word(addr);
`else
    e.err  = 1'b0;
    e.data = rom_word(addr);
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy    = 1'b0;
    m_port    = 1'b0;
    m_owed    = 1'b0;
    last_data = 32'h0;
    last_err  = 1'b0;
    sbq.delete();
  endfunction

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [1:0] rr);
    logic        free;
    logic        grant;
    logic        who;
    logic [31:0] addr;
    req_valid  = rv;
    req_addr0  = a0;
    req_addr1  = a1;
    resp_ready = rr;
    free  = !m_busy || rr[m_port];
    who   = (rv == 2'b11) ? m_owed : rv[1];
    grant = (rv != 2'b00) && free;
    addr  = who ? a1 : a0;
    @(negedge clk);
    check("req_ready", 64'(req_ready), grant ? 64'(2'b01 << who) : 64'h0);
    check("rom_addr", 64'(rom_addr), grant ? 64'(addr) : 64'h0);
    @(posedge clk);
    if (grant) begin
      sbq.push_back(expected_resp(who, addr));
      m_busy = 1'b1;
      m_port = who;
      m_owed = ~who;
    end else if (m_busy && rr[m_port]) begin
      m_busy = 1'b0;
    end
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      check("resp_valid_onehot", 64'($countones(resp_valid) <= 1), 64'h1);
      if (resp_valid != 2'b00) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", 64'(resp_valid), 64'h0);
        end else begin
          check("resp_port", 64'(resp_valid), 64'(2'b01 << sbq[0].port));
          check("resp_data", 64'(resp_data), 64'(sbq[0].data));
          check("resp_err", 64'(resp_err), 64'(sbq[0].err));
          last_data = sbq[0].data;
          last_err  = sbq[0].err;
          if (resp_ready[sbq[0].port]) void'(sbq.pop_front());
        end
      end else begin
        check("pending_resp_missing", 64'(sbq.size()), 64'h0);
        check("idle_data_kept", 64'(resp_data), 64'(last_data));
        check("idle_err_kept", 64'(resp_err), 64'(last_err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_addr0  = 32'h0;
    req_addr1  = 32'h8;
    resp_ready = 2'b00;
    #3;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_data", 64'(resp_data), 64'h0);
    check("rst_resp_err", 64'(resp_err), 64'h0);
    req_valid = 2'b00;
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention right after reset: port 0 first, then strict alternation.
    for (int i = 0; i < 6; i++) step(2'b11, 32'h0, 32'h8, 2'b11);
    step(2'b00, 32'h0, 32'h0, 2'b11);

    // Single fetch, then release to idle.
    step(2'b01, 32'h4, 32'h0, 2'b11);
    step(2'b00, 32'h0, 32'h0, 2'b11);
    step(2'b00, 32'h0, 32'h0, 2'b11);

    // Backpressure on port 1 while port 0 waits; port 0 is granted as port 1 drains.
    step(2'b10, 32'h0, 32'h0, 2'b00);
    for (int i = 0; i < 3; i++) step(2'b01, 32'h4, 32'h0, 2'b00);
    step(2'b01, 32'h4, 32'h0, 2'b10);
    step(2'b00, 32'h0, 32'h0, 2'b11);
    step(2'b00, 32'h0, 32'h0, 2'b11);

    // Misaligned then aligned access.
    step(2'b01, 32'h6, 32'h0, 2'b11);
    step(2'b01, 32'h4, 32'h0, 2'b11);
    step(2'b00, 32'h0, 32'h0, 2'b11);

    // Randomized traffic with random backpressure and occasional misalignment.
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), 32'($urandom_range(0, 63)),
           {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
    end
    for (int i = 0; i < 3; i++) step(2'b00, 32'h0, 32'h0, 2'b11);

    // Asynchronous reset while a response is held.
    step(2'b10, 32'h0, 32'h4, 2'b00);
    req_valid = 2'b01;
    #2;
    model_reset();
    rst_n = 1'b0;
    #1;
    check("async_rst_resp_valid", 64'(resp_valid), 64'h0);
    check("async_rst_req_ready", 64'(req_ready), 64'h0);
    req_valid = 2'b00;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(2'b11, 32'h8, 32'h4, 2'b11);
    step(2'b11, 32'h8, 32'h4, 2'b11);
    for (int i = 0; i < 3; i++) step(2'b00, 32'h0, 32'h0, 2'b11);

    check("scoreboard_drained", 64'(sbq.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
